// File: rtl/sram10t_ctrl_if.sv
// Command/response bundle between an initiator and the SRAM10T array controller.
// Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready are both 1.
interface sram10t_ctrl_if #(
   parameter int AW = 12,
   parameter int CW = 13
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [AW-1:0] cmd_addr1;
   logic [AW-1:0] cmd_addr2;
   logic          cmd_data;
   logic          cmd_alt;
   logic          rsp_valid;
   logic          rsp_rd1;
   logic          rsp_rd2;
   logic [CW-1:0] rsp_count;
   logic          busy;

   modport master (
      output cmd_valid, cmd_op, cmd_addr1, cmd_addr2, cmd_data, cmd_alt,
      input  cmd_ready, rsp_valid, rsp_rd1, rsp_rd2, rsp_count, busy
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr1, cmd_addr2, cmd_data, cmd_alt,
      output cmd_ready, rsp_valid, rsp_rd1, rsp_rd2, rsp_count, busy
   );
endinterface

// File: rtl/sram10t_ctrl.sv
// Initiator-side controller for the SRAM10T 4096x1 dual-read-port array:
// single READ2/WRITE commands plus whole-array FILL and COUNT sweeps.
module sram10t_ctrl #(
   parameter int AW = 12,
   parameter int CW = 13
) (
   input  logic          clk,
   input  logic          rst,
   sram10t_ctrl_if.slave bus,
   output logic [AW-1:0] sram_addr1,
   output logic [AW-1:0] sram_addr2,
   output logic          sram_rdwr,
   output logic          sram_den,
   output logic          sram_wline,
   input  logic          sram_rl1,
   input  logic          sram_rl2,
   output logic [2:0]    dbg_state
);
   typedef enum logic [2:0] {
      IDLE, RD_ISSUE, RD_CAPT, WR, FILL, CNT_RUN, CNT_DRAIN
   } state_t;

   localparam logic [1:0] OP_READ2 = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_FILL  = 2'b10;
   localparam logic [1:0] OP_COUNT = 2'b11;
   localparam logic [AW-1:0] ADDR_LAST = '1;
   localparam logic [AW-1:0] PAIR_LAST = {{(AW-1){1'b1}}, 1'b0};

   state_t        state, state_nx;
   logic          accept;
   logic          den_nx, rdwr_nx, wline_nx, rsp_fire;
   logic [AW-1:0] addr1_nx, addr2_nx;
   logic          fill_data, fill_alt;
   logic          cnt_pend;
   logic [CW-1:0] acc, pair_sum;
   logic          rsp_valid_q, rd1_q, rd2_q;
   logic [CW-1:0] count_q;

   assign accept    = bus.cmd_valid && (state == IDLE);
   assign pair_sum  = {{(CW-1){1'b0}}, sram_rl1} + {{(CW-1){1'b0}}, sram_rl2};
   assign dbg_state = state;

   assign bus.cmd_ready = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rd1   = rd1_q;
   assign bus.rsp_rd2   = rd2_q;
   assign bus.rsp_count = count_q;

   // Array pins are computed for the next cycle so every sram_* output is a flop.
   always_comb begin
      state_nx = state;
      den_nx   = 1'b0;
      rdwr_nx  = 1'b1;
      wline_nx = 1'b0;
      addr1_nx = sram_addr1;
      addr2_nx = sram_addr2;
      rsp_fire = 1'b0;
      case (state)
         IDLE: begin
            if (bus.cmd_valid) begin
               den_nx = 1'b1;
               case (bus.cmd_op)
                  OP_READ2: begin
                     state_nx = RD_ISSUE;
                     addr1_nx = bus.cmd_addr1;
                     addr2_nx = bus.cmd_addr2;
                  end
                  OP_WRITE: begin
                     state_nx = WR;
                     rdwr_nx  = 1'b0;
                     addr1_nx = bus.cmd_addr1;
                     wline_nx = bus.cmd_data;
                  end
                  OP_FILL: begin
                     state_nx = FILL;
                     rdwr_nx  = 1'b0;
                     addr1_nx = '0;
                     wline_nx = bus.cmd_data;
                  end
                  default: begin
                     state_nx = CNT_RUN;
                     addr1_nx = '0;
                     addr2_nx = AW'(1);
                  end
               endcase
            end
         end
         RD_ISSUE: state_nx = RD_CAPT;
         RD_CAPT: begin
            state_nx = IDLE;
            rsp_fire = 1'b1;
         end
         WR: begin
            state_nx = IDLE;
            rsp_fire = 1'b1;
         end
         FILL: begin
            if (sram_addr1 == ADDR_LAST) begin
               state_nx = IDLE;
               rsp_fire = 1'b1;
            end else begin
               den_nx   = 1'b1;
               rdwr_nx  = 1'b0;
               addr1_nx = sram_addr1 + AW'(1);
               wline_nx = fill_data ^ (~sram_addr1[0] & fill_alt);
            end
         end
         CNT_RUN: begin
            if (sram_addr1 == PAIR_LAST) begin
               state_nx = CNT_DRAIN;
            end else begin
               den_nx   = 1'b1;
               addr1_nx = sram_addr1 + AW'(2);
               addr2_nx = sram_addr1 + AW'(3);
            end
         end
         CNT_DRAIN: begin
            state_nx = IDLE;
            rsp_fire = 1'b1;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         sram_den    <= 1'b0;
         sram_rdwr   <= 1'b1;
         sram_wline  <= 1'b0;
         sram_addr1  <= '0;
         sram_addr2  <= '0;
         rsp_valid_q <= 1'b0;
         rd1_q       <= 1'b0;
         rd2_q       <= 1'b0;
         count_q     <= '0;
         fill_data   <= 1'b0;
         fill_alt    <= 1'b0;
         cnt_pend    <= 1'b0;
         acc         <= '0;
      end else begin
         state       <= state_nx;
         sram_den    <= den_nx;
         sram_rdwr   <= rdwr_nx;
         sram_wline  <= wline_nx;
         sram_addr1  <= addr1_nx;
         sram_addr2  <= addr2_nx;
         rsp_valid_q <= rsp_fire;
         // Read data for an issue lands one cycle later, so accumulation lags issue by one.
         cnt_pend    <= (state == CNT_RUN);
         if (accept) begin
            fill_data <= bus.cmd_data;
            fill_alt  <= bus.cmd_alt;
            acc       <= '0;
         end else if (cnt_pend) begin
            acc <= acc + pair_sum;
         end
         if (state == RD_CAPT) begin
            rd1_q <= sram_rl1;
            rd2_q <= sram_rl2;
         end
         if (state == CNT_DRAIN) begin
            count_q <= acc + pair_sum;
         end
      end
   end
endmodule

// File: tb/tb_sram10t_ctrl.sv
// Bench for sram10t_ctrl: behavioural array model, command table, response
// scoreboard with due-cycle checking, and hand-written reset/back-to-back sequences.
module tb_sram10t_ctrl;
   localparam int AW = 12;
   localparam int CW = 13;
   localparam logic [1:0] OP_READ2 = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_FILL  = 2'b10;
   localparam logic [1:0] OP_COUNT = 2'b11;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   sram10t_ctrl_if #(.AW(AW), .CW(CW)) bus ();
   logic [AW-1:0] sram_addr1, sram_addr2;
   logic          sram_rdwr, sram_den, sram_wline;
   logic          sram_rl1 = 1'b0;
   logic          sram_rl2 = 1'b0;
   logic [2:0]    dbg_state;

   sram10t_ctrl #(.AW(AW), .CW(CW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave),
      .sram_addr1(sram_addr1),
      .sram_addr2(sram_addr2),
      .sram_rdwr(sram_rdwr),
      .sram_den(sram_den),
      .sram_wline(sram_wline),
      .sram_rl1(sram_rl1),
      .sram_rl2(sram_rl2),
      .dbg_state(dbg_state)
   );

   // array model: write at closing edge, read data presented the following cycle
   logic mem [0:4095];
   initial for (int i = 0; i < 4096; i++) mem[i] = 1'b0;
   always @(posedge clk) begin
      if (sram_den && !sram_rdwr) mem[sram_addr1] <= sram_wline;
      if (sram_den && sram_rdwr) begin
         sram_rl1 <= mem[sram_addr1];
         sram_rl2 <= mem[sram_addr2];
      end
   end

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // scoreboard entry: {op[1:0], due_cycle[31:0], rd1, rd2, count[12:0]}
   logic [48:0] exp_q[$];

   always @(negedge clk) begin
      logic [48:0] e;
      if (!rst && bus.rsp_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d want none", cyc);
         end else begin
            e = exp_q.pop_front();
            check("rsp_cycle", cyc, e[46:15]);
            check("rsp_ready", bus.cmd_ready, 1);
            if (e[48:47] == OP_READ2) begin
               check("rsp_rd1", bus.rsp_rd1, e[14]);
               check("rsp_rd2", bus.rsp_rd2, e[13]);
            end
            if (e[48:47] == OP_COUNT) check("rsp_count", bus.rsp_count, e[12:0]);
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || !bus.cmd_ready) && n < 5000) begin
         tick();
         n++;
      end
      check("idle_timeout", (n < 5000) ? 1 : 0, 1);
   endtask

   task automatic send(input logic [1:0] op, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic d, input logic alt, input int lat,
                       input logic e1, input logic e2, input logic [CW-1:0] ecnt);
      int acc_cyc;
      int n = 0;
      while (!bus.cmd_ready && n < 5000) begin
         tick();
         n++;
      end
      check("ready_timeout", bus.cmd_ready, 1);
      bus.cmd_op    = op;
      bus.cmd_addr1 = a1;
      bus.cmd_addr2 = a2;
      bus.cmd_data  = d;
      bus.cmd_alt   = alt;
      bus.cmd_valid = 1'b1;
      acc_cyc = cyc;
      if (lat > 0) exp_q.push_back({op, 32'(acc_cyc + lat), e1, e2, ecnt});
      tick();
      bus.cmd_valid = 1'b0;
      check("issue_den", sram_den, 1);
      check("issue_rdwr", sram_rdwr, (op == OP_READ2 || op == OP_COUNT) ? 1 : 0);
      if (op == OP_READ2) begin
         check("issue_addr1", sram_addr1, a1);
         check("issue_addr2", sram_addr2, a2);
      end
      if (op == OP_WRITE) check("issue_wline", sram_wline, d);
      if (op == OP_FILL) check("fill_addr0", sram_addr1, 0);
      if (op == OP_COUNT) check("count_addr2", sram_addr2, 1);
   endtask

   typedef struct {
      logic [1:0]    op;
      logic [AW-1:0] a1;
      logic [AW-1:0] a2;
      logic          d;
      logic          alt;
      int            lat;
      logic          rd1;
      logic          rd2;
      logic [CW-1:0] cnt;
   } vec_t;

   vec_t vecs [9];

   initial begin
      int c;
      logic [AW-1:0] ra;
      logic rb;

      vecs[0] = '{OP_WRITE, 12'd123,  12'd0,    1'b1, 1'b0, 2,    1'b0, 1'b0, 13'd0};
      vecs[1] = '{OP_WRITE, 12'd124,  12'd0,    1'b0, 1'b0, 2,    1'b0, 1'b0, 13'd0};
      vecs[2] = '{OP_READ2, 12'd123,  12'd124,  1'b0, 1'b0, 3,    1'b1, 1'b0, 13'd0};
      vecs[3] = '{OP_WRITE, 12'd0,    12'd0,    1'b1, 1'b0, 2,    1'b0, 1'b0, 13'd0};
      vecs[4] = '{OP_READ2, 12'd0,    12'd0,    1'b0, 1'b0, 3,    1'b1, 1'b1, 13'd0};
      vecs[5] = '{OP_FILL,  12'd0,    12'd0,    1'b0, 1'b1, 4097, 1'b0, 1'b0, 13'd0};
      vecs[6] = '{OP_COUNT, 12'd0,    12'd0,    1'b0, 1'b0, 2050, 1'b0, 1'b0, 13'd2048};
      vecs[7] = '{OP_READ2, 12'd4094, 12'd4095, 1'b0, 1'b0, 3,    1'b0, 1'b1, 13'd0};
      vecs[8] = '{OP_FILL,  12'd0,    12'd0,    1'b1, 1'b0, 4097, 1'b0, 1'b0, 13'd0};

      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_addr1 = '0;
      bus.cmd_addr2 = '0;
      bus.cmd_data  = 1'b0;
      bus.cmd_alt   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      check("rst_ready", bus.cmd_ready, 1);
      check("rst_busy", bus.busy, 0);
      check("rst_den", sram_den, 0);
      check("rst_rdwr", sram_rdwr, 1);
      check("rst_addr1", sram_addr1, 0);
      check("rst_addr2", sram_addr2, 0);
      check("rst_wline", sram_wline, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rd1", bus.rsp_rd1, 0);
      check("rst_rd2", bus.rsp_rd2, 0);
      check("rst_count", bus.rsp_count, 0);
      check("rst_state", dbg_state, 0);

      for (int i = 0; i < 9; i++) begin
         send(vecs[i].op, vecs[i].a1, vecs[i].a2, vecs[i].d, vecs[i].alt, vecs[i].lat,
              vecs[i].rd1, vecs[i].rd2, vecs[i].cnt);
         wait_idle();
      end
      send(OP_COUNT, 12'd0, 12'd0, 1'b0, 1'b0, 2050, 1'b0, 1'b0, 13'd4096);
      wait_idle();

      // reset in the middle of a FILL of ones
      send(OP_FILL, 12'd0, 12'd0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 13'd0);
      c = cyc - 1;
      while (cyc < c + 100) tick();
      check("abort_den_before", sram_den, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_den_after", sram_den, 0);
      check("abort_ready", bus.cmd_ready, 1);
      check("abort_busy", bus.busy, 0);
      repeat (20) tick();
      check("abort_ready_later", bus.cmd_ready, 1);
      send(OP_WRITE, 12'd0, 12'd0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 13'd0);
      wait_idle();
      send(OP_READ2, 12'd0, 12'd0, 1'b0, 1'b0, 3, 1'b0, 1'b0, 13'd0);
      wait_idle();

      // cmd_valid held through a READ2: second copy accepted with the first response
      bus.cmd_op    = OP_READ2;
      bus.cmd_addr1 = 12'd50;
      bus.cmd_addr2 = 12'd0;
      bus.cmd_valid = 1'b1;
      c = cyc;
      exp_q.push_back({OP_READ2, 32'(c + 3), 1'b1, 1'b0, 13'd0});
      exp_q.push_back({OP_READ2, 32'(c + 6), 1'b1, 1'b0, 13'd0});
      tick();
      check("hold_ready_c1", bus.cmd_ready, 0);
      tick();
      check("hold_ready_c2", bus.cmd_ready, 0);
      check("hold_den_c2", sram_den, 0);
      tick();
      check("hold_ready_c3", bus.cmd_ready, 1);
      check("hold_den_c3", sram_den, 0);
      tick();
      check("hold_den_c4", sram_den, 1);
      bus.cmd_valid = 1'b0;
      wait_idle();

      // random write/read-back pairs
      for (int i = 0; i < 4; i++) begin
         ra = AW'($urandom_range(0, 4095));
         rb = 1'($urandom_range(0, 1));
         send(OP_WRITE, ra, 12'd0, rb, 1'b0, 2, 1'b0, 1'b0, 13'd0);
         wait_idle();
         send(OP_READ2, ra, ra, 1'b0, 1'b0, 3, rb, rb, 13'd0);
         wait_idle();
      end

      repeat (5) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
